// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional bubble counter enabled by ID_EX_STALL_CNT_EN.
module id_ex_register #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic [7:0]            ctrl_i,
  input  logic [DATA_W-1:0]     rs_data_i,
  input  logic [DATA_W-1:0]     rt_data_i,
  input  logic [DATA_W-1:0]     imm_i,
  input  logic [REG_ADDR_W-1:0] rs_addr_i,
  input  logic [REG_ADDR_W-1:0] rt_addr_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  output logic [7:0]            ctrl_o,
  output logic [DATA_W-1:0]     rs_data_o,
  output logic [DATA_W-1:0]     rt_data_o,
  output logic [DATA_W-1:0]     imm_o,
  output logic [REG_ADDR_W-1:0] rs_addr_o,
  output logic [REG_ADDR_W-1:0] rt_addr_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic                  valid_o,
  output logic                  hazard_o
`ifdef ID_EX_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt_o
`endif
);

  typedef struct packed {
    logic [7:0]            ctrl;
    logic [DATA_W-1:0]     rs_data;
    logic [DATA_W-1:0]     rt_data;
    logic [DATA_W-1:0]     imm;
    logic [REG_ADDR_W-1:0] rs_addr;
    logic [REG_ADDR_W-1:0] rt_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  valid;
  } id_ex_t;

  id_ex_t q;
  id_ex_t d;
  logic   rt_hit;
  logic   bubble;

  assign rt_hit = (q.rt_addr == rs_addr_i) | (q.rt_addr == rt_addr_i);

  // A load in EX whose target is read by ID must wait one cycle.
  assign hazard_o = q.valid & q.ctrl[4] & (q.rt_addr != '0) & rt_hit;
  assign bubble   = flush_i | hazard_o;

  always_comb begin
    d = '{
      ctrl:    ctrl_i,
      rs_data: rs_data_i,
      rt_data: rt_data_i,
      imm:     imm_i,
      rs_addr: rs_addr_i,
      rt_addr: rt_addr_i,
      rd_addr: rd_addr_i,
      valid:   1'b1
    };
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q <= '0;
    end else if (!stall_i) begin
      if (bubble) q <= '0;
      else        q <= d;
    end
  end

  assign ctrl_o    = q.ctrl;
  assign rs_data_o = q.rs_data;
  assign rt_data_o = q.rt_data;
  assign imm_o     = q.imm;
  assign rs_addr_o = q.rs_addr;
  assign rt_addr_o = q.rt_addr;
  assign rd_addr_o = q.rd_addr;
  assign valid_o   = q.valid;

`ifdef ID_EX_STALL_CNT_EN
  // Counts load-use bubbles only; saturates instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if (!stall_i && hazard_o && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_register.sv
// Self-checking bench for id_ex_register against a transaction-level model.
// Counter scenarios are exercised when ID_EX_STALL_CNT_EN is defined.
module tb_id_ex_register;

`ifdef ID_EX_STALL_CNT_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 16;
`endif
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [7:0] LW    = 8'b1101_0001;
  localparam logic [7:0] RTYPE = 8'b0100_1110;

  logic        clk_i = 1'b0;
  logic        rst_i, stall_i, flush_i;
  logic [7:0]  ctrl_i;
  logic [31:0] rs_data_i, rt_data_i, imm_i;
  logic [4:0]  rs_addr_i, rt_addr_i, rd_addr_i;
  logic [7:0]  ctrl_o;
  logic [31:0] rs_data_o, rt_data_o, imm_o;
  logic [4:0]  rs_addr_o, rt_addr_o, rd_addr_o;
  logic        valid_o, hazard_o;
`ifdef ID_EX_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_o;
`endif

  id_ex_register #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .ctrl_i(ctrl_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
    .imm_i(imm_i), .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
    .rd_addr_i(rd_addr_i), .ctrl_o(ctrl_o), .rs_data_o(rs_data_o),
    .rt_data_o(rt_data_o), .imm_o(imm_o), .rs_addr_o(rs_addr_o),
    .rt_addr_o(rt_addr_o), .rd_addr_o(rd_addr_o), .valid_o(valid_o),
    .hazard_o(hazard_o)
`ifdef ID_EX_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0]  ctrl;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic        valid;
  } st_t;

  int  n_checks = 0;
  int  n_fail   = 0;
  st_t m;
  int  m_cnt;

  function automatic st_t dut_st();
    return {ctrl_o, rs_data_o, rt_data_o, imm_o,
            rs_addr_o, rt_addr_o, rd_addr_o, valid_o};
  endfunction

  // EX holds a real load whose non-zero target is read by the ID instruction.
  function automatic logic model_haz();
    if (!m.valid || !m.ctrl[4] || m.rt_addr == 0) return 1'b0;
    return (m.rt_addr == rs_addr_i) || (m.rt_addr == rt_addr_i);
  endfunction

  task automatic set_in(input logic [7:0] c, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd);
    ctrl_i    = c;
    rs_addr_i = rs;
    rt_addr_i = rt;
    rd_addr_i = rd;
    rs_data_i = $urandom;
    rt_data_i = $urandom;
    imm_i     = $urandom;
  endtask

  task automatic tick();
    st_t nxt;
    logic h;
    h   = model_haz();
    nxt = m;
    if (rst_i) begin
      nxt   = '0;
      m_cnt = 0;
    end else if (!stall_i) begin
      if (h && m_cnt < CNT_MAX) m_cnt++;
      if (flush_i || h) nxt = '0;
      else nxt = {ctrl_i, rs_data_i, rt_data_i, imm_i,
                  rs_addr_i, rt_addr_i, rd_addr_i, 1'b1};
    end
    @(posedge clk_i);
    m = nxt;
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    set_in(LW, 5'd3, 5'd3, 5'd4);
    tick();
    tick();
    n_checks++;
    if (dut_st() !== st_t'(0)) begin
      n_fail++;
      $display("FAIL reset_state got=%h exp=0", dut_st());
    end
    n_checks++;
    if (hazard_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hazard got=%b exp=0", hazard_o);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_load();
    set_in(RTYPE, 5'd1, 5'd2, 5'd3);
    rs_data_i = 32'h11;
    tick();
    n_checks++;
    if (ctrl_o !== RTYPE || rs_data_o !== 32'h11 || valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL load ctrl=%b rs=%h v=%b exp ctrl=%b rs=11 v=1",
               ctrl_o, rs_data_o, valid_o, RTYPE);
    end
    n_checks++;
    if (dut_st() !== m) begin
      n_fail++;
      $display("FAIL load_full got=%h exp=%h", dut_st(), m);
    end
  endtask

  task automatic test_load_use();
    set_in(LW, 5'd1, 5'd8, 5'd0);
    tick();
    set_in(RTYPE, 5'd8, 5'd2, 5'd9);
    #1;
    n_checks++;
    if (hazard_o !== 1'b1) begin
      n_fail++;
      $display("FAIL load_use_hazard got=%b exp=1", hazard_o);
    end
    tick();
    n_checks++;
    if (ctrl_o !== 8'h00 || valid_o !== 1'b0 || hazard_o !== 1'b0) begin
      n_fail++;
      $display("FAIL load_use_bubble ctrl=%h v=%b hz=%b exp 00/0/0",
               ctrl_o, valid_o, hazard_o);
    end
    tick();
    n_checks++;
    if (valid_o !== 1'b1 || rs_addr_o !== 5'd8 || ctrl_o !== RTYPE) begin
      n_fail++;
      $display("FAIL load_use_resume v=%b rs=%0d ctrl=%b exp 1/8/%b",
               valid_o, rs_addr_o, ctrl_o, RTYPE);
    end
  endtask

  task automatic test_r0();
    set_in(LW, 5'd4, 5'd0, 5'd0);
    tick();
    set_in(RTYPE, 5'd0, 5'd0, 5'd6);
    #1;
    n_checks++;
    if (hazard_o !== 1'b0) begin
      n_fail++;
      $display("FAIL r0_hazard got=%b exp=0", hazard_o);
    end
    tick();
    n_checks++;
    if (valid_o !== 1'b1 || ctrl_o !== RTYPE) begin
      n_fail++;
      $display("FAIL r0_no_bubble v=%b ctrl=%b exp 1/%b",
               valid_o, ctrl_o, RTYPE);
    end
  endtask

  task automatic test_flush();
    int cnt_before;
    cnt_before = m_cnt;
    set_in(RTYPE, 5'd1, 5'd2, 5'd3);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    n_checks++;
    if (ctrl_o !== 8'h00 || valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush ctrl=%h v=%b exp 00/0", ctrl_o, valid_o);
    end
`ifdef ID_EX_STALL_CNT_EN
    n_checks++;
    if (stall_cnt_o !== cnt_before[CNT_W-1:0]) begin
      n_fail++;
      $display("FAIL flush_cnt got=%0d exp=%0d", stall_cnt_o, cnt_before);
    end
`endif
  endtask

  task automatic test_freeze();
    st_t held;
    set_in(LW, 5'd2, 5'd9, 5'd0);
    tick();
    held = m;
    stall_i = 1'b1;
    flush_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(8'($urandom), 5'd9, 5'($urandom), 5'($urandom));
      #1;
      n_checks++;
      if (hazard_o !== 1'b1) begin
        n_fail++;
        $display("FAIL freeze_hazard cyc=%0d got=%b exp=1", i, hazard_o);
      end
      tick();
      n_checks++;
      if (dut_st() !== held) begin
        n_fail++;
        $display("FAIL freeze_hold cyc=%0d got=%h exp=%h", i, dut_st(), held);
      end
    end
    stall_i = 1'b0;
    tick();
    flush_i = 1'b0;
    n_checks++;
    if (dut_st() !== st_t'(0)) begin
      n_fail++;
      $display("FAIL freeze_release got=%h exp=0", dut_st());
    end
  endtask

  task automatic test_back_to_back();
    int bubbles;
    bubbles = 0;
    set_in(LW, 5'd1, 5'd5, 5'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      // alternate: a load that depends on the previous load
      set_in(LW, (k % 2 == 0) ? 5'd5 : 5'd6, (k % 2 == 0) ? 5'd6 : 5'd5, 5'd0);
      for (int c = 0; c < 2; c++) begin
        #1;
        if (hazard_o === 1'b1) bubbles++;
        tick();
      end
    end
    n_checks++;
    if (bubbles != 4) begin
      n_fail++;
      $display("FAIL back_to_back bubbles=%0d exp=4", bubbles);
    end
    n_checks++;
    if (dut_st() !== m) begin
      n_fail++;
      $display("FAIL back_to_back_state got=%h exp=%h", dut_st(), m);
    end
  endtask

  task automatic test_reset_mid_hazard();
    set_in(LW, 5'd1, 5'd7, 5'd0);
    tick();
    set_in(RTYPE, 5'd7, 5'd7, 5'd2);
    stall_i = 1'b1;
    rst_i   = 1'b1;
    tick();
    rst_i   = 1'b0;
    stall_i = 1'b0;
    n_checks++;
    if (dut_st() !== st_t'(0) || hazard_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid got=%h hz=%b exp=0/0", dut_st(), hazard_o);
    end
    tick();
    n_checks++;
    if (valid_o !== 1'b1 || rs_addr_o !== 5'd7) begin
      n_fail++;
      $display("FAIL reset_mid_resume v=%b rs=%0d exp 1/7", valid_o, rs_addr_o);
    end
  endtask

`ifdef ID_EX_STALL_CNT_EN
  task automatic test_counter();
    int exp_cnt;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_in(LW, 5'd7, 5'd7, 5'd0);
      tick();
      tick();
      exp_cnt = (i + 1 > 3) ? 3 : i + 1;
      n_checks++;
      if (stall_cnt_o !== exp_cnt[CNT_W-1:0]) begin
        n_fail++;
        $display("FAIL counter i=%0d got=%0d exp=%0d", i, stall_cnt_o, exp_cnt);
      end
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    n_checks++;
    if (stall_cnt_o !== '0) begin
      n_fail++;
      $display("FAIL counter_reset got=%0d exp=0", stall_cnt_o);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_i   = ($urandom_range(0, 99) < 3);
      stall_i = ($urandom_range(0, 99) < 12);
      flush_i = ($urandom_range(0, 99) < 10);
      set_in(($urandom_range(0, 1) != 0) ? LW : 8'($urandom),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom));
      #1;
      n_checks++;
      if (hazard_o !== model_haz()) begin
        n_fail++;
        $display("FAIL rand_hazard i=%0d got=%b exp=%b", i, hazard_o, model_haz());
      end
      tick();
      n_checks++;
      if (dut_st() !== m) begin
        n_fail++;
        $display("FAIL rand_state i=%0d got=%h exp=%h", i, dut_st(), m);
      end
`ifdef ID_EX_STALL_CNT_EN
      n_checks++;
      if (stall_cnt_o !== m_cnt[CNT_W-1:0]) begin
        n_fail++;
        $display("FAIL rand_cnt i=%0d got=%0d exp=%0d", i, stall_cnt_o, m_cnt);
      end
`endif
    end
    rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
  endtask

  initial begin
    m     = '0;
    m_cnt = 0;
    test_reset();
    test_load();
    test_load_use();
    test_r0();
    test_flush();
    test_freeze();
    test_back_to_back();
    test_reset_mid_hazard();
`ifdef ID_EX_STALL_CNT_EN
    test_counter();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_register.md
Name: id_ex_register

Overview:
- ID/EX pipeline register for the 5-stage MIPS core. Sits directly downstream of the instruction-decode control unit.
- Captures the 8-bit EX/M/WB control bundle, register-file read data, sign-extended immediate and register addresses each cycle.
- Contains the load-use hazard detector: it inserts a bubble and requests a PC/IF-ID freeze.
- Honours external freeze and branch/jump flush.

Parameters:
- DATA_W, 32, width of register data and immediate paths.
- REG_ADDR_W, 5, register address width.
- CNT_W, 16, width of the stall counter (optional feature only).

Ports:
- clk_i  in  1  clock, all state updates on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- stall_i  in  1  external freeze (e.g. memory wait); holds all state.
- flush_i  in  1  branch/jump taken; the entry loaded this cycle becomes a bubble.
- ctrl_i  in  8  control bundle: [0] ALUSrc, [2:1] ALUOp, [3] RegDst, [4] MemRead, [5] MemWrite, [6] RegWrite, [7] MemtoReg.
- rs_data_i  in  DATA_W  rs read data.
- rt_data_i  in  DATA_W  rt read data.
- imm_i  in  DATA_W  sign-extended immediate.
- rs_addr_i, rt_addr_i, rd_addr_i  in  REG_ADDR_W  ID-stage register addresses.
- ctrl_o  out  8  registered control bundle.
- rs_data_o, rt_data_o, imm_o  out  DATA_W  registered data.
- rs_addr_o, rt_addr_o, rd_addr_o  out  REG_ADDR_W  registered addresses.
- valid_o  out  1  EX-stage entry is a real instruction.
- hazard_o  out  1  load-use stall request to PC and IF/ID (combinational).
- stall_cnt_o  out  CNT_W  bubbles inserted (present only with macro).

Behaviour:
- Reset (rst_i=1 at clock edge): all outputs and registers become 0; valid_o=0; hazard_o=0 because it derives from valid_o=0.
- hazard_o = valid_o & ctrl_o[4] & (rt_addr_o!=0) & ((rt_addr_o==rs_addr_i) | (rt_addr_o==rt_addr_i)). Purely combinational, no added latency.
- Per-edge priority: rst_i > stall_i > flush_i > hazard_o > normal load.
  - stall_i=1: every register holds its value, including valid_o. hazard_o keeps evaluating on the held state. flush_i is ignored; upstream keeps flush_i high until stall_i drops.
  - flush_i=1 or hazard_o=1: insert a bubble. ctrl_o, all data and address outputs become 0; valid_o=0.
  - Otherwise: load all inputs; valid_o=1. Latency is 1 cycle from input to output.
- A bubble clears ctrl_o[4], so a load-use hazard lasts exactly one cycle. On the next edge the held ID instruction loads normally.
- Back-to-back loads, each followed by a dependent instruction, produce one bubble per pair.
- Register r0 never triggers a hazard.
- Reset asserted mid-stall or mid-hazard: the reset state wins at that edge. There is no residual stall afterwards.

Optional Feature:
- Macro ID_EX_STALL_CNT_EN.
- Defined: stall_cnt_o exists. It increments by 1 on every edge where a hazard bubble is inserted (hazard_o=1, stall_i=0, rst_i=0). Flush bubbles are not counted. It saturates at all-ones and clears on reset.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset and load: assert rst_i, then load ctrl_i=8'b0100_1110 with rs_data_i=32'h11 → after reset all outputs are 0. One cycle after load, ctrl_o=8'b0100_1110, rs_data_o=32'h11, valid_o=1.
- Load-use hazard:
  - Stimulus: load lw with ctrl_i=8'b1101_0001, rt_addr_i=8; next ID presents rs_addr_i=8.
  - Response: hazard_o=1 that cycle. Next edge ctrl_o=0, valid_o=0, hazard_o=0.
  - Following edge: the dependent instruction loads.
- r0 exemption: lw with rt_addr_i=0, then an instruction with rs_addr_i=0 → hazard_o stays 0 and no bubble is inserted.
- Flush: flush_i=1 while an R-type instruction (ctrl_i=8'b0100_1110) is presented → next cycle ctrl_o=0 and valid_o=0. With the macro defined, stall_cnt_o is unchanged.
- Freeze:
  - Stimulus: stall_i=1 for 3 cycles while inputs change and flush_i=1.
  - Response: all outputs hold their values. After stall_i drops with flush_i still high, a bubble is inserted.
- Counter: with ID_EX_STALL_CNT_EN and CNT_W=2, force 5 hazard bubbles → stall_cnt_o reads 1, 2, 3, 3, 3. Reset returns it to 0.
